// File: rtl/core_pkg.sv
// Shared types and constants for the two-requester core front end.
// Requester ids travel through the tag FIFO, so they are kept to a single bit.
package core_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ0    = 1'b0;
    localparam req_id_t REQ1    = 1'b1;
    localparam int      NUM_REQ = 2;

    // Grant lock: open arbitration, or held on a requester the core has stalled.
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/core_tag_fifo.sv
// Tag FIFO: remembers which requester issued each outstanding instruction.
// The head entry is read combinationally so results can be steered in the same cycle.
module core_tag_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     push,
    input  req_id_t                  push_id,
    input  logic                     pop,
    output req_id_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    req_id_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // Guard here as well so a misbehaving parent cannot corrupt the pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_CLK) begin
                if (i_RST) begin
                    mem_q[gi] <= REQ0;
                end else if (do_push && (wr_ptr_q == PW'(gi))) begin
                    mem_q[gi] <= push_id;
                end
            end
        end
    endgenerate

    // Pointers are exactly PW bits, so the increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/core_arbiter.sv
// Round-robin front end: merges two instruction sources onto the core's single
// port and returns each result to the requester that issued it, in issue order.
module core_arbiter
    import core_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic [INSTR_WIDTH-1:0]  i_instr0,
    input  logic [INSTR_WIDTH-1:0]  i_instr1,
    input  logic                    i_valid0,
    input  logic                    i_valid1,
    output logic                    o_ready0,
    output logic                    o_ready1,
    output logic [INSTR_WIDTH-1:0]  o_instr,
    output logic                    o_valid,
    input  logic                    i_ready,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_dvalid,
    output logic                    o_dready,
    output logic [DATA_WIDTH-1:0]   o_data0,
    output logic [DATA_WIDTH-1:0]   o_data1,
    output logic                    o_dvalid0,
    output logic                    o_dvalid1,
    input  logic                    i_dready0,
    input  logic                    i_dready1,
    output logic                    o_busy,
    output logic                    o_err
);

    arb_state_e               state_q, state_d;
    req_id_t                  lock_id_q, lock_id_d;
    req_id_t                  prio_q, prio_d;
    logic                     err_q, err_d;

    req_id_t                  winner;
    logic                     issue;
    logic                     pop;
    req_id_t                  head_id;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     ret_ok;

    core_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .push    (issue),
        .push_id (winner),
        .pop     (pop),
        .head    (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ---------------- grant-lock FSM: state register ----------------
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q   <= ARB_OPEN;
            lock_id_q <= REQ0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    // ---------------- grant-lock FSM: next state ----------------
    // A stalled grant must stay put so the core sees a stable instruction word.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ARB_OPEN: begin
                if (o_valid && !i_ready) begin
                    state_d   = ARB_LOCKED;
                    lock_id_d = winner;
                end
            end
            ARB_LOCKED: begin
                if (issue) begin
                    state_d = ARB_OPEN;
                end
            end
            default: begin
                state_d = ARB_OPEN;
            end
        endcase
    end

    // ---------------- grant-lock FSM: outputs (winner select) ----------------
    always_comb begin
        winner = REQ0;
        if (state_q == ARB_LOCKED) begin
            winner = lock_id_q;
        end else if (i_valid0 && i_valid1) begin
            winner = prio_q;
        end else if (i_valid1) begin
            winner = REQ1;
        end else begin
            winner = REQ0;
        end
    end

    // ---------------- issue path ----------------
    // Full is judged on the registered count, so a same-cycle pop does not free a slot.
    assign o_valid  = (i_valid0 || i_valid1) && !fifo_full && !i_RST;
    assign o_instr  = (winner == REQ1) ? i_instr1 : i_instr0;
    assign issue    = o_valid && i_ready;
    assign o_ready0 = issue && (winner == REQ0);
    assign o_ready1 = issue && (winner == REQ1);

    // ---------------- return path ----------------
    assign ret_ok    = !fifo_empty && !i_RST;
    assign o_dvalid0 = i_dvalid && ret_ok && (head_id == REQ0);
    assign o_dvalid1 = i_dvalid && ret_ok && (head_id == REQ1);
    assign o_dready  = ret_ok && ((head_id == REQ1) ? i_dready1 : i_dready0);
    assign pop       = i_dvalid && o_dready;
    assign o_data0   = i_data;
    assign o_data1   = i_data;

    assign o_busy    = (fifo_count != '0) && !i_RST;
    assign o_err     = err_q;

    // ---------------- round-robin priority and error flag ----------------
    always_comb begin
        prio_d = prio_q;
        err_d  = err_q;
        if (issue) begin
            prio_d = other_req(winner);
        end
        // A result with nothing outstanding means the core and this block disagree.
        if (i_dvalid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            prio_q <= REQ0;
            err_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_core_arbiter.sv
// Bench for core_arbiter: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model of the arbitration rules.
module tb_core_arbiter;
    import core_pkg::*;

    localparam int IW    = 32;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [IW-1:0] instr0, instr1;
    logic          v0, v1;
    logic          core_ready;
    logic [DW-1:0] core_data;
    logic          core_dvalid;
    logic          dready0, dready1;

    logic          o_ready0, o_ready1, o_valid, o_dready;
    logic [IW-1:0] o_instr;
    logic [DW-1:0] o_data0, o_data1;
    logic          o_dvalid0, o_dvalid1, o_busy, o_err;

    core_arbiter #(.INSTR_WIDTH(IW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_CLK(clk), .i_RST(rst),
        .i_instr0(instr0), .i_instr1(instr1),
        .i_valid0(v0), .i_valid1(v1),
        .o_ready0(o_ready0), .o_ready1(o_ready1),
        .o_instr(o_instr), .o_valid(o_valid), .i_ready(core_ready),
        .i_data(core_data), .i_dvalid(core_dvalid), .o_dready(o_dready),
        .o_data0(o_data0), .o_data1(o_data1),
        .o_dvalid0(o_dvalid0), .o_dvalid1(o_dvalid1),
        .i_dready0(dready0), .i_dready1(dready1),
        .o_busy(o_busy), .o_err(o_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: outstanding tags in issue order.
    bit q[$];
    bit m_prio, m_locked, m_lock_id, m_err;

    // Outcome of the most recent cycle, plus sampled DUT outputs.
    bit e_issue, e_win, e_pop;
    logic s_valid, s_ready0, s_ready1, s_dready, s_dvalid0, s_dvalid1, s_busy, s_err;
    logic [IW-1:0] s_instr;
    int iss_q[$];
    int rx0[$];
    int rx1[$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit full, empty, ev, win, h, e_dr;
        @(negedge clk);
        s_valid = o_valid;   s_ready0 = o_ready0; s_ready1 = o_ready1;
        s_dready = o_dready; s_dvalid0 = o_dvalid0; s_dvalid1 = o_dvalid1;
        s_busy = o_busy;     s_err = o_err;       s_instr = o_instr;
        if (o_ready0) iss_q.push_back(0);
        if (o_ready1) iss_q.push_back(1);
        if (o_dvalid0 && o_dready) rx0.push_back(int'(o_data0));
        if (o_dvalid1 && o_dready) rx1.push_back(int'(o_data1));

        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (m_locked)      win = m_lock_id;
        else if (v0 && v1) win = m_prio;
        else               win = v1;
        ev   = (v0 || v1) && !full && !rst;
        h    = empty ? 1'b0 : q[0];
        e_dr = !empty && !rst && (h ? dready1 : dready0);

        chk1("o_valid", o_valid, ev);
        if (ev) chkw("o_instr", o_instr, win ? instr1 : instr0);
        chk1("o_ready0", o_ready0, ev && core_ready && !win);
        chk1("o_ready1", o_ready1, ev && core_ready && win);
        chk1("o_dvalid0", o_dvalid0, core_dvalid && !empty && !rst && !h);
        chk1("o_dvalid1", o_dvalid1, core_dvalid && !empty && !rst && h);
        chk1("o_dready", o_dready, e_dr);
        chk1("o_busy", o_busy, (q.size() != 0) && !rst);
        chk1("o_err", o_err, m_err);
        if (o_dvalid0) chkw("o_data0", 32'(o_data0), 32'(core_data));
        if (o_dvalid1) chkw("o_data1", 32'(o_data1), 32'(core_data));

        e_issue = ev && core_ready;
        e_win   = win;
        e_pop   = core_dvalid && e_dr;

        @(posedge clk);
        if (rst) begin
            q.delete();
            m_prio = 0; m_locked = 0; m_lock_id = 0; m_err = 0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_issue) begin
                q.push_back(win);
                m_prio   = !win;
                m_locked = 0;
            end else if (ev) begin
                m_locked  = 1;
                m_lock_id = win;
            end
            if (core_dvalid && empty) m_err = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; v0 = 0; v1 = 0; core_dvalid = 0; core_ready = 0;
        dready0 = 1; dready1 = 1;
        cycle();
        rst = 0;
        iss_q.delete(); rx0.delete(); rx1.delete();
    endtask

    initial begin
        int nret;
        logic [DW-1:0] dl [4];
        dl[0] = 8'h11; dl[1] = 8'h22; dl[2] = 8'h33; dl[3] = 8'h44;
        instr0 = 32'hA000_0000; instr1 = 32'hB000_0000; core_data = '0;
        m_prio = 0; m_locked = 0; m_lock_id = 0; m_err = 0;

        // Reset state
        do_reset();
        cycle();
        chk1("rst_busy", s_busy, 1'b0);
        chk1("rst_err", s_err, 1'b0);
        chk1("rst_valid", s_valid, 1'b0);

        // Alternation with in-order echo
        do_reset();
        v0 = 1; v1 = 1; core_ready = 1; nret = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin v0 = 0; v1 = 0; end
            core_dvalid = (q.size() != 0) && (nret < 4);
            core_data   = dl[nret % 4];
            cycle();
            if (e_pop) nret++;
            if (e_issue) begin
                if (e_win) instr1 = instr1 + 1;
                else       instr0 = instr0 + 1;
            end
        end
        core_dvalid = 0;
        for (int i = 0; i < 4; i++)
            chkw($sformatf("alt_iss%0d", i), 32'((i < iss_q.size()) ? iss_q[i] : 99), 32'(i % 2));
        chkw("alt_rx0_a", 32'((rx0.size() > 0) ? rx0[0] : 0), 32'h11);
        chkw("alt_rx0_b", 32'((rx0.size() > 1) ? rx0[1] : 0), 32'h33);
        chkw("alt_rx1_a", 32'((rx1.size() > 0) ? rx1[0] : 0), 32'h22);
        chkw("alt_rx1_b", 32'((rx1.size() > 1) ? rx1[1] : 0), 32'h44);

        // Grant lock: req1 stalled, req0 arrives later
        do_reset();
        v1 = 1; instr1 = 32'h1111_0001;
        cycle();
        v0 = 1; instr0 = 32'h0000_0002;
        cycle();
        chkw("lock_instr_c2", s_instr, 32'h1111_0001);
        cycle();
        chkw("lock_instr_c3", s_instr, 32'h1111_0001);
        core_ready = 1;
        cycle();
        v1 = 0;
        cycle();
        v0 = 0;
        chkw("lock_iss_n", 32'(iss_q.size()), 32'd2);
        chkw("lock_iss0", 32'((iss_q.size() > 0) ? iss_q[0] : 99), 32'd1);
        chkw("lock_iss1", 32'((iss_q.size() > 1) ? iss_q[1] : 99), 32'd0);
        core_dvalid = 1; cycle(); cycle(); core_dvalid = 0;
        cycle();
        chk1("lock_drained", s_busy, 1'b0);

        // Full FIFO: four issues, no results
        do_reset();
        core_ready = 1; v0 = 1; v1 = 1;
        repeat (4) cycle();
        cycle();
        chk1("full_valid", s_valid, 1'b0);
        chk1("full_ready0", s_ready0, 1'b0);
        chk1("full_ready1", s_ready1, 1'b0);
        chk1("full_busy", s_busy, 1'b1);
        core_dvalid = 1;
        cycle();
        chk1("full_pop_dready", s_dready, 1'b1);
        chk1("full_pop_valid", s_valid, 1'b0);
        core_dvalid = 0;
        cycle();
        chk1("full_next_valid", s_valid, 1'b1);
        chk1("full_next_ready", s_ready0 | s_ready1, 1'b1);
        v0 = 0; v1 = 0; core_dvalid = 1;
        repeat (4) cycle();
        core_dvalid = 0;

        // Result backpressure on head tag 0
        do_reset();
        core_ready = 1; v0 = 1;
        cycle();
        v0 = 0; core_dvalid = 1; dready0 = 0; dready1 = 1;
        repeat (2) begin
            cycle();
            chk1("bp_dready", s_dready, 1'b0);
            chk1("bp_dvalid1", s_dvalid1, 1'b0);
            chk1("bp_dvalid0", s_dvalid0, 1'b1);
        end
        dready0 = 1;
        cycle();
        chk1("bp_pop", s_dready, 1'b1);
        core_dvalid = 0;
        cycle();
        chk1("bp_busy", s_busy, 1'b0);

        // Spurious result on an empty FIFO
        do_reset();
        core_dvalid = 1;
        cycle();
        chk1("spur_dready", s_dready, 1'b0);
        chk1("spur_err_now", s_err, 1'b0);
        core_dvalid = 0;
        cycle();
        chk1("spur_err_next", s_err, 1'b1);
        repeat (3) cycle();
        chk1("spur_err_sticky", s_err, 1'b1);
        do_reset();
        cycle();
        chk1("spur_err_cleared", s_err, 1'b0);

        // Mid-run reset with two outstanding
        do_reset();
        core_ready = 1; v0 = 1;
        cycle();
        v0 = 0; v1 = 1;
        cycle();
        v1 = 0;
        cycle();
        chk1("mid_busy_before", s_busy, 1'b1);
        rst = 1;
        cycle();
        chk1("mid_busy_in_rst", s_busy, 1'b0);
        rst = 0; iss_q.delete();
        cycle();
        chk1("mid_busy_after", s_busy, 1'b0);
        chk1("mid_err_after", s_err, 1'b0);
        v0 = 1; v1 = 1;
        cycle();
        v0 = 0; v1 = 0;
        chkw("mid_grant0", 32'((iss_q.size() > 0) ? iss_q[0] : 99), 32'd0);
        core_dvalid = 1; cycle(); core_dvalid = 0;

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            core_ready = ($urandom_range(3, 0) != 0);
            if (!v0 && ($urandom_range(1, 0) != 0)) begin v0 = 1; instr0 = $urandom; end
            if (!v1 && ($urandom_range(1, 0) != 0)) begin v1 = 1; instr1 = $urandom; end
            core_dvalid = (q.size() != 0) ? ($urandom_range(1, 0) != 0) : ($urandom_range(63, 0) == 0);
            core_data   = DW'($urandom);
            dready0     = ($urandom_range(3, 0) != 0);
            dready1     = ($urandom_range(3, 0) != 0);
            rst         = ($urandom_range(399, 0) == 0);
            cycle();
            rst = 0;
            if (e_issue) begin
                if (e_win) v1 = 0;
                else       v0 = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
